// File: rtl/conv_layer_ctrl_if.sv
// Bus bundle between conv_layer_ctrl and its weight memory, activation memory,
// convolver and output memory.
//
// Strobe semantics: w_rd_en / act_rd_en are single-cycle read strobes with no
// back-pressure; the memory returns w_rd_data / act_rd_data on the cycle after
// the strobe. out_wr_en is a single-cycle write strobe qualifying out_addr and
// out_wr_data on the same cycle. valid_conv qualifies conv_op on its own cycle
// and is only honoured while conv_ce is high.
interface conv_layer_ctrl_if #(
    parameter int K   = 3,
    parameter int AW  = 16,
    parameter int WAW = 8
);
    logic              w_rd_en;
    logic [WAW-1:0]    w_addr;
    logic [15:0]       w_rd_data;
    logic              act_rd_en;
    logic [AW-1:0]     act_addr;
    logic [15:0]       act_rd_data;
    logic [K*K*16-1:0] weight1;
    logic              conv_rst;
    logic              conv_ce;
    logic [15:0]       activation;
    logic [32:0]       conv_op;
    logic              valid_conv;
    logic              out_wr_en;
    logic [AW-1:0]     out_addr;
    logic [32:0]       out_wr_data;

    modport master (
        output w_rd_en, w_addr, act_rd_en, act_addr, weight1, conv_rst, conv_ce,
               activation, out_wr_en, out_addr, out_wr_data,
        input  w_rd_data, act_rd_data, conv_op, valid_conv
    );

    modport slave (
        input  w_rd_en, w_addr, act_rd_en, act_addr, weight1, conv_rst, conv_ce,
               activation, out_wr_en, out_addr, out_wr_data,
        output w_rd_data, act_rd_data, conv_op, valid_conv
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Sequencer for one convolver: per start pulse it loads the K*K weights,
// clears the convolver, streams the N*N activation map, drains the pipeline
// and writes every valid result to output memory before pulsing done.
module conv_layer_ctrl #(
    parameter int N         = 10,
    parameter int K         = 3,
    parameter int S         = 1,
    parameter int AW        = 16,
    parameter int WAW       = 8,
    parameter int DRAIN_MAX = 64
) (
    input  logic       clk,
    input  logic       global_rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state,
    conv_layer_ctrl_if.master bus
);
    localparam int          OUT_DIM   = (N - K) / S + 1;
    localparam logic [31:0] OUT_TOTAL = 32'(OUT_DIM * OUT_DIM);
    localparam logic [31:0] KK        = 32'(K * K);
    localparam logic [31:0] NN_LAST   = 32'(N * N - 1);
    localparam logic [31:0] DRAIN_END = 32'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, CLR, STREAM, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] w_cnt, act_cnt, out_cnt, drain_cnt;
    logic        ce_q;        // an activation read was issued last cycle
    logic        conv_rst_q;  // convolver clear following reset or abort
    logic        set_error;
    logic        abort_take;
    logic        capture;

    assign abort_take = abort && (state != IDLE);
    assign capture    = bus.valid_conv && bus.conv_ce && (out_cnt < OUT_TOTAL);

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign dbg_state     = state;
    assign bus.w_rd_en   = (state == LOAD_W) && (w_cnt < KK);
    assign bus.w_addr    = bus.w_rd_en ? w_cnt[WAW-1:0] : '0;
    assign bus.act_rd_en = (state == STREAM);
    assign bus.act_addr  = bus.act_rd_en ? act_cnt[AW-1:0] : '0;
    assign bus.conv_rst  = conv_rst_q || (state == CLR);
    // Streaming ce follows the read by one cycle so data and ce line up;
    // during drain ce stays high and the convolver is fed zeros.
    assign bus.conv_ce    = ce_q || (state == DRAIN);
    assign bus.activation = ce_q ? bus.act_rd_data : 16'd0;

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        set_error = 1'b0;
        case (state)
            IDLE:   if (start && !abort) state_nxt = LOAD_W;
            LOAD_W: if (w_cnt == KK) state_nxt = CLR;
            CLR:    state_nxt = STREAM;
            STREAM: if (act_cnt == NN_LAST) state_nxt = DRAIN;
            DRAIN: begin
                if (out_cnt == OUT_TOTAL) begin
                    state_nxt = DONE;
                end else if (drain_cnt == DRAIN_END) begin
                    state_nxt = DONE;
                    set_error = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_take) begin
            state_nxt = IDLE;
            set_error = 1'b0;
        end
    end

    // State register, pass counters and the sticky error flag.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state      <= IDLE;
            w_cnt      <= '0;
            act_cnt    <= '0;
            out_cnt    <= '0;
            drain_cnt  <= '0;
            ce_q       <= 1'b0;
            conv_rst_q <= 1'b1;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            conv_rst_q <= abort_take;
            ce_q       <= bus.act_rd_en && !abort_take;
            if (set_error) begin
                error <= 1'b1;
            end else if (state == IDLE && start && !abort) begin
                error <= 1'b0;
            end
            if (state == IDLE) begin
                w_cnt     <= '0;
                act_cnt   <= '0;
                out_cnt   <= '0;
                drain_cnt <= '0;
            end else begin
                if (state == LOAD_W) w_cnt <= w_cnt + 32'd1;
                if (state == STREAM) act_cnt <= act_cnt + 32'd1;
                if (state == DRAIN) drain_cnt <= drain_cnt + 32'd1;
                if (capture) out_cnt <= out_cnt + 32'd1;
            end
        end
    end

    // Weight slot j is filled on the cycle after its read (w_cnt == j+1).
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            bus.weight1 <= '0;
        end else if (state == LOAD_W) begin
            for (int i = 0; i < K * K; i++) begin
                if (w_cnt == 32'(i + 1)) bus.weight1[16*i +: 16] <= bus.w_rd_data;
            end
        end
    end

    // Output write one cycle after capture; an abort cancels the pending write.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            bus.out_wr_en   <= 1'b0;
            bus.out_addr    <= '0;
            bus.out_wr_data <= '0;
        end else begin
            bus.out_wr_en <= capture && !abort_take;
            if (capture) begin
                bus.out_addr    <= out_cnt[AW-1:0];
                bus.out_wr_data <= bus.conv_op;
            end
        end
    end
endmodule
